preg_rename_ctrl: RTL and testbench
===================================

// Module: preg_rename_ctrl
// PURPOSE
//  Rename-stage controller for the 2-way OoO core: owns the physical-register free list.
//  Allocates up to SCALAR new pregs per cycle for dispatching instrs and drives the RAT write port.
//  Reclaims T_old tags at retire; sequences RAT/free-list recovery on rollback.
//  Sits between decode/dispatch and the RAT; drives the global rename stall.
// PARAMETERS
//  NUM_AREG   32  architectural regs; pregs 0..NUM_AREG-1 are the reset mapping
//  NUM_PREG   64  physical regs; free-list depth FL_DEPTH = NUM_PREG-NUM_AREG = 32
//  SCALAR     2   dispatch/retire width (only 2 supported)
// PORTS
//  clock            in   1                       system clock
//  reset            in   1                       synchronous, active-high
//  rollback         in   1                       mispredict flush from ROB head
//  stall_in         in   1                       downstream (ROB/RS) full
//  disp_valid       in   [SCALAR]                slot i dispatching; slot1 never valid without slot0
//  disp_has_dest    in   [SCALAR]                slot writes rd != x0
//  disp_dest_areg   in   [SCALAR][5]             rd of slot i
//  retire_valid     in   [SCALAR]                slot i retiring this cycle
//  retire_has_dest  in   [SCALAR]                retiring instr wrote a reg
//  retire_told      in   [SCALAR][PREG_IDX_WIDTH] T_old to free
//  rename_stall     out  1                       dispatch must hold both slots
//  alloc_valid      out  [SCALAR]                slot i received a new preg
//  alloc_tag        out  [SCALAR][PREG_IDX_WIDTH] new preg (T) for slot i
//  rat_write_packet out  RAT_WRITE_INPACKET[SCALAR] {write_en, addr, tag} to RAT
//  free_count       out  $clog2(FL_DEPTH)+1      entries currently on spec free list
// BEHAVIOUR
//  - Storage: circular tag buffer fl[FL_DEPTH]; spec_head, arch_head, tail are 5b idx + 1 wrap bit.
//  - Reset: fl[k]=NUM_AREG+k, spec_head=arch_head=0, tail=FL_DEPTH (wrap=1,idx=0), free_count=32.
//    State RUN. While reset high, all outputs except free_count are 0.
//  - FSM: RUN, RECOVER.
//    RUN->RECOVER on rollback; RECOVER->RUN after exactly 1 cycle unless rollback again (stays).
//    RECOVER covers the cycle the RAT copies RRAT.
//  - need = popcount(disp_valid & disp_has_dest); combinational, same cycle.
//  - rename_stall = (state==RECOVER) | rollback | stall_in | (need > free_count).
//  - Allocation is all-or-nothing: if rename_stall, alloc_valid=0, rat write_en=0, spec_head holds.
//  - Otherwise slot0 with dest takes fl[spec_head].
//    Slot1 with dest takes next entry: fl[spec_head+1] if slot0 took one, else fl[spec_head].
//    spec_head += need at posedge.
//  - rat_write_packet[i] = {alloc_valid[i], disp_dest_areg[i], alloc_tag[i]}.
//    Same rd in both slots gives two distinct tags; RAT resolves the intra-bundle bypass.
//  - Retire (processed every non-reset cycle, incl. rollback and RECOVER):
//    each slot with retire_valid&has_dest writes retire_told into fl[tail] (slot0 first),
//    then tail advances.
//  - Each retiring dest also advances arch_head by 1, since allocation order equals retire order.
//  - Tags freed in cycle N become allocatable in N+1 (free_count is registered).
//  - Rollback (priority over dispatch): spec_head <= arch_head + this cycle's retire advance;
//    free_count <= tail_next - arch_head_next.
//  - free_count = tail - spec_head; range 0..32; the wrap bit disambiguates full from empty.
//  - Invariant assertions:
//    free_count never >32 (retire overflow is an error);
//    free_count never <0;
//    disp_valid[1] implies disp_valid[0].
//  - reset mid-operation (incl. during RECOVER) fully reinitialises; pending allocations are lost.
// STRUCTURE
//  - Shared package (sys_defs): PREG_IDX_WIDTH, RAT_WRITE_INPACKET (existing),
//    new FL_RETIRE_PACKET {valid, has_dest, told}, FL_DEPTH localparam.
//  - Single module; no sub-module needed. Pointer arithmetic is in a local function ptr_add(ptr, n).
// TESTING
//  1. Reset, 2 dispatch dests r1,r2
//     -> alloc_tag=32,33; rat write {r1,32},{r2,33}; free_count 32->30.
//  2. Slot0 rd=x0, slot1 rd=r5
//     -> alloc_valid=01, slot1 gets 32, spec_head +1, free_count=31.
//  3. Drain to free_count=1, dispatch 2 dests
//     -> rename_stall=1, no RAT write, count stays 1.
//     Same cycle retire T_old=7: next cycle count=2, dispatch proceeds.
//  4. Allocate 4 (32..35), retire first 2 (T_old 1,2), then rollback
//     -> RECOVER 1 cycle with stall=1.
//     spec_head = arch_head (idx 2); count=32; next allocs are 34,35.
//  5. Rollback coincident with retire of 1 dest
//     -> arch_head includes that retire; freed T_old present after recovery.
//     Rollback again in RECOVER stays RECOVER.
//  6. Reset asserted in RECOVER with count=10
//     -> next cycle RUN, count=32, fl restored to 32..63, no outputs asserted during reset.

Source files
------------

// File: rtl/preg_rename_ctrl_pkg.sv
// Shared rename-stage definitions: register-file geometry, free-list pointer types,
// RAT write and retire packets, and the rename controller state encoding.
package preg_rename_ctrl_pkg;

    localparam int NUM_AREG       = 32;
    localparam int NUM_PREG       = 64;
    localparam int SCALAR         = 2;
    localparam int AREG_IDX_WIDTH = $clog2(NUM_AREG);
    localparam int PREG_IDX_WIDTH = $clog2(NUM_PREG);
    localparam int FL_DEPTH       = NUM_PREG - NUM_AREG;
    localparam int FL_IDX_WIDTH   = $clog2(FL_DEPTH);
    localparam int FL_PTR_WIDTH   = FL_IDX_WIDTH + 1;
    localparam int FC_WIDTH       = $clog2(FL_DEPTH) + 1;

    typedef logic [PREG_IDX_WIDTH-1:0] preg_tag_t;
    typedef logic [AREG_IDX_WIDTH-1:0] areg_idx_t;
    typedef logic [FL_PTR_WIDTH-1:0]   fl_ptr_t;

    typedef struct packed {
        logic      write_en;
        areg_idx_t addr;
        preg_tag_t tag;
    } RAT_WRITE_INPACKET;

    typedef struct packed {
        logic      valid;
        logic      has_dest;
        preg_tag_t told;
    } FL_RETIRE_PACKET;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } rename_state_t;

    function automatic logic [1:0] count2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/preg_rename_ctrl_if.sv
// Dispatch/retire/rollback bundle between decode, the ROB and the rename controller.
// The master side drives requests; the slave side (the controller) answers with grants.
interface preg_rename_ctrl_if
    import preg_rename_ctrl_pkg::*;
();

    logic                                    rollback;
    logic                                    stall_in;
    logic [SCALAR-1:0]                       disp_valid;
    logic [SCALAR-1:0]                       disp_has_dest;
    logic [SCALAR-1:0][AREG_IDX_WIDTH-1:0]   disp_dest_areg;
    logic [SCALAR-1:0]                       retire_valid;
    logic [SCALAR-1:0]                       retire_has_dest;
    logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]   retire_told;

    logic                                    rename_stall;
    logic [SCALAR-1:0]                       alloc_valid;
    logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]   alloc_tag;
    RAT_WRITE_INPACKET [SCALAR-1:0]          rat_write_packet;
    logic [FC_WIDTH-1:0]                     free_count;

    modport master (
        output rollback, stall_in,
        output disp_valid, disp_has_dest, disp_dest_areg,
        output retire_valid, retire_has_dest, retire_told,
        input  rename_stall, alloc_valid, alloc_tag, rat_write_packet, free_count
    );

    modport slave (
        input  rollback, stall_in,
        input  disp_valid, disp_has_dest, disp_dest_areg,
        input  retire_valid, retire_has_dest, retire_told,
        output rename_stall, alloc_valid, alloc_tag, rat_write_packet, free_count
    );

endinterface

// File: rtl/preg_rename_ctrl.sv
// Rename-stage controller: owns the circular physical-register free list, hands out
// new tags to dispatch, reclaims T_old at retire and restores the list on rollback.
module preg_rename_ctrl
    import preg_rename_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    preg_rename_ctrl_if.slave  rn
);

    function automatic fl_ptr_t ptr_add(input fl_ptr_t ptr, input logic [1:0] n);
        return ptr + fl_ptr_t'(n);
    endfunction

    rename_state_t        state, state_next;
    preg_tag_t            fl [FL_DEPTH];
    fl_ptr_t              spec_head, arch_head, tail;
    logic [FC_WIDTH-1:0]  free_count_q;

    logic                 take0, take1;
    logic [1:0]           need;
    logic                 stall_raw;
    logic                 grant;
    fl_ptr_t              slot1_ptr;
    logic [SCALAR-1:0]    alloc_valid;
    preg_tag_t            alloc_tag [SCALAR];

    FL_RETIRE_PACKET      ret_pkt [SCALAR];
    logic [SCALAR-1:0]    ret_fire;
    logic [1:0]           ret_cnt;
    logic                 wr0_en, wr1_en;
    preg_tag_t            wr0_data, wr1_data;
    fl_ptr_t              wr1_ptr;

    fl_ptr_t              tail_next, arch_head_next, spec_head_next;
    logic [FC_WIDTH-1:0]  free_count_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // RECOVER lasts exactly one cycle (the RAT copying the RRAT) unless rollback repeats.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (rn.rollback) state_next = RECOVER;
            RECOVER: state_next = rn.rollback ? RECOVER : RUN;
            default: state_next = RUN;
        endcase
    end

    // Allocation is all-or-nothing across both slots; the stall is held low during reset.
    always_comb begin
        take0     = rn.disp_valid[0] & rn.disp_has_dest[0];
        take1     = rn.disp_valid[1] & rn.disp_has_dest[1];
        need      = count2({take1, take0});
        stall_raw = (state == RECOVER) | rn.rollback | rn.stall_in
                  | (FC_WIDTH'(need) > free_count_q);
        grant     = ~reset & ~stall_raw;

        alloc_valid[0] = grant & take0;
        alloc_valid[1] = grant & take1;
        slot1_ptr      = take0 ? ptr_add(spec_head, 2'd1) : spec_head;

        alloc_tag[0] = alloc_valid[0] ? fl[spec_head[FL_IDX_WIDTH-1:0]] : '0;
        alloc_tag[1] = alloc_valid[1] ? fl[slot1_ptr[FL_IDX_WIDTH-1:0]] : '0;
    end

    always_comb begin
        for (int i = 0; i < SCALAR; i++) begin
            ret_pkt[i].valid    = rn.retire_valid[i];
            ret_pkt[i].has_dest = rn.retire_has_dest[i];
            ret_pkt[i].told     = rn.retire_told[i];
            ret_fire[i]         = ret_pkt[i].valid & ret_pkt[i].has_dest;
        end
        ret_cnt  = count2(ret_fire);

        wr0_en   = ret_fire[0] | ret_fire[1];
        wr0_data = ret_fire[0] ? ret_pkt[0].told : ret_pkt[1].told;
        wr1_en   = ret_fire[0] & ret_fire[1];
        wr1_data = ret_pkt[1].told;
        wr1_ptr  = ptr_add(tail, 2'd1);
    end

    // Retires advance arch_head in lockstep with tail because retire order equals allocation order.
    always_comb begin
        tail_next      = ptr_add(tail, ret_cnt);
        arch_head_next = ptr_add(arch_head, ret_cnt);
        if (rn.rollback) begin
            spec_head_next = arch_head_next;
        end else begin
            spec_head_next = ptr_add(spec_head, grant ? need : 2'd0);
        end
        free_count_next = FC_WIDTH'(tail_next - spec_head_next);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                fl[k] <= PREG_IDX_WIDTH'(NUM_AREG + k);
            end
            spec_head    <= '0;
            arch_head    <= '0;
            tail         <= fl_ptr_t'(FL_DEPTH);
            free_count_q <= FC_WIDTH'(FL_DEPTH);
        end else begin
            if (wr0_en) fl[tail[FL_IDX_WIDTH-1:0]]    <= wr0_data;
            if (wr1_en) fl[wr1_ptr[FL_IDX_WIDTH-1:0]] <= wr1_data;
            spec_head    <= spec_head_next;
            arch_head    <= arch_head_next;
            tail         <= tail_next;
            free_count_q <= free_count_next;
        end
    end

    // An out-of-range count can only come from over-retiring or under-flowing the list.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (free_count_next <= FC_WIDTH'(FL_DEPTH));
            assert (!(rn.disp_valid[1] && !rn.disp_valid[0]));
        end
    end

    assign rn.rename_stall = ~reset & stall_raw;
    assign rn.alloc_valid  = alloc_valid;
    assign rn.free_count   = free_count_q;

    always_comb begin
        for (int i = 0; i < SCALAR; i++) begin
            rn.alloc_tag[i]                 = alloc_tag[i];
            rn.rat_write_packet[i].write_en = alloc_valid[i];
            rn.rat_write_packet[i].addr     = alloc_valid[i] ? rn.disp_dest_areg[i] : '0;
            rn.rat_write_packet[i].tag      = alloc_tag[i];
        end
    end

endmodule

// File: tb/tb_preg_rename_ctrl.sv
// Directed bench for preg_rename_ctrl: allocation, stall, retire reclaim, rollback recovery
// and reset during RECOVER, each compared against hand-computed values.
module tb_preg_rename_ctrl;
    import preg_rename_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    preg_rename_ctrl_if rn();

    preg_rename_ctrl dut (
        .clock (clock),
        .reset (reset),
        .rn    (rn)
    );

    task automatic applyStimulus(input logic [1:0] dv, input logic [1:0] dh,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [1:0] rv, input logic [1:0] rh,
                                 input logic [5:0] t0, input logic [5:0] t1,
                                 input logic rb, input logic st);
        rn.disp_valid        = dv;
        rn.disp_has_dest     = dh;
        rn.disp_dest_areg[0] = a0;
        rn.disp_dest_areg[1] = a1;
        rn.retire_valid      = rv;
        rn.retire_has_dest   = rh;
        rn.retire_told[0]    = t0;
        rn.retire_told[1]    = t1;
        rn.rollback          = rb;
        rn.stall_in          = st;
        #1;
    endtask

    task automatic idle();
        applyStimulus(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic dispatch2(input logic [4:0] a0, input logic [4:0] a1);
        applyStimulus(2'b11, 2'b11, a0, a1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Test 1: two dests right after reset
        checkOutput("t1_reset_count", 32'(rn.free_count), 32'd32);
        checkOutput("t1_reset_stall", 32'(rn.rename_stall), 32'd0);
        dispatch2(5'd1, 5'd2);
        checkOutput("t1_alloc_valid", 32'(rn.alloc_valid), 32'd3);
        checkOutput("t1_tag0", 32'(rn.alloc_tag[0]), 32'd32);
        checkOutput("t1_tag1", 32'(rn.alloc_tag[1]), 32'd33);
        checkOutput("t1_rat0", 32'(rn.rat_write_packet[0]), {20'd0, 1'b1, 5'd1, 6'd32});
        checkOutput("t1_rat1", 32'(rn.rat_write_packet[1]), {20'd0, 1'b1, 5'd2, 6'd33});
        tick();
        idle();
        checkOutput("t1_count_after", 32'(rn.free_count), 32'd30);

        // Test 2: slot0 writes x0, slot1 writes r5
        doReset();
        applyStimulus(2'b11, 2'b10, 5'd0, 5'd5, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        checkOutput("t2_alloc_valid", 32'(rn.alloc_valid), 32'd2);
        checkOutput("t2_tag1", 32'(rn.alloc_tag[1]), 32'd32);
        checkOutput("t2_rat0", 32'(rn.rat_write_packet[0]), 32'd0);
        checkOutput("t2_rat1", 32'(rn.rat_write_packet[1]), {20'd0, 1'b1, 5'd5, 6'd32});
        tick();
        applyStimulus(2'b01, 2'b01, 5'd3, 5'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        checkOutput("t2_count", 32'(rn.free_count), 32'd31);
        checkOutput("t2_next_tag", 32'(rn.alloc_tag[0]), 32'd33);
        tick();

        // Test 3: starvation, then a same-cycle retire unblocks dispatch
        doReset();
        for (int i = 0; i < 15; i++) begin
            dispatch2(5'd1, 5'd2);
            tick();
        end
        applyStimulus(2'b01, 2'b01, 5'd4, 5'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(2'b11, 2'b11, 5'd6, 5'd7, 2'b01, 2'b01, 6'd7, 6'd0, 1'b0, 1'b0);
        checkOutput("t3_count_one", 32'(rn.free_count), 32'd1);
        checkOutput("t3_stall", 32'(rn.rename_stall), 32'd1);
        checkOutput("t3_no_alloc", 32'(rn.alloc_valid), 32'd0);
        checkOutput("t3_no_rat", 32'(rn.rat_write_packet[0]), 32'd0);
        tick();
        dispatch2(5'd6, 5'd7);
        checkOutput("t3_count_two", 32'(rn.free_count), 32'd2);
        checkOutput("t3_unstall", 32'(rn.rename_stall), 32'd0);
        checkOutput("t3_tag0", 32'(rn.alloc_tag[0]), 32'd63);
        checkOutput("t3_tag1", 32'(rn.alloc_tag[1]), 32'd7);
        tick();
        applyStimulus(2'b01, 2'b01, 5'd8, 5'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        checkOutput("t3_empty_count", 32'(rn.free_count), 32'd0);
        checkOutput("t3_empty_stall", 32'(rn.rename_stall), 32'd1);
        idle();
        applyStimulus(2'b11, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
        checkOutput("t3_stall_in", 32'(rn.rename_stall), 32'd1);
        idle();

        // Test 4: allocate four, retire two, roll back
        doReset();
        dispatch2(5'd1, 5'd2);
        tick();
        dispatch2(5'd3, 5'd4);
        checkOutput("t4_tag2", 32'(rn.alloc_tag[0]), 32'd34);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 5'd0, 2'b11, 2'b11, 6'd1, 6'd2, 1'b0, 1'b0);
        checkOutput("t4_count28", 32'(rn.free_count), 32'd28);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
        checkOutput("t4_count30", 32'(rn.free_count), 32'd30);
        checkOutput("t4_rb_stall", 32'(rn.rename_stall), 32'd1);
        tick();
        dispatch2(5'd1, 5'd2);
        checkOutput("t4_recover_stall", 32'(rn.rename_stall), 32'd1);
        checkOutput("t4_recover_noalloc", 32'(rn.alloc_valid), 32'd0);
        checkOutput("t4_recover_count", 32'(rn.free_count), 32'd32);
        tick();
        dispatch2(5'd1, 5'd2);
        checkOutput("t4_run_stall", 32'(rn.rename_stall), 32'd0);
        checkOutput("t4_tag0", 32'(rn.alloc_tag[0]), 32'd34);
        checkOutput("t4_tag1", 32'(rn.alloc_tag[1]), 32'd35);
        tick();
        idle();

        // Test 5: rollback with a coincident retire, then rollback again in RECOVER
        doReset();
        dispatch2(5'd1, 5'd2);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 5'd0, 2'b01, 2'b01, 6'd5, 6'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
        checkOutput("t5_count", 32'(rn.free_count), 32'd32);
        checkOutput("t5_recover_stall", 32'(rn.rename_stall), 32'd1);
        tick();
        dispatch2(5'd1, 5'd2);
        checkOutput("t5_still_recover", 32'(rn.rename_stall), 32'd1);
        tick();
        dispatch2(5'd1, 5'd2);
        checkOutput("t5_run_stall", 32'(rn.rename_stall), 32'd0);
        checkOutput("t5_tag0", 32'(rn.alloc_tag[0]), 32'd33);
        checkOutput("t5_tag1", 32'(rn.alloc_tag[1]), 32'd34);
        tick();
        for (int i = 0; i < 14; i++) begin
            dispatch2(5'd1, 5'd2);
            tick();
        end
        dispatch2(5'd1, 5'd2);
        checkOutput("t5_count2", 32'(rn.free_count), 32'd2);
        checkOutput("t5_wrap_tag0", 32'(rn.alloc_tag[0]), 32'd63);
        checkOutput("t5_freed_told", 32'(rn.alloc_tag[1]), 32'd5);
        tick();
        idle();

        // Test 6: reset while in RECOVER
        doReset();
        for (int i = 0; i < 11; i++) begin
            dispatch2(5'd1, 5'd2);
            tick();
        end
        applyStimulus(2'b00, 2'b00, 5'd0, 5'd0, 2'b11, 2'b11, 6'd3, 6'd4, 1'b1, 1'b0);
        checkOutput("t6_count10", 32'(rn.free_count), 32'd10);
        tick();
        reset = 1'b1;
        dispatch2(5'd9, 5'd10);
        checkOutput("t6_reset_stall", 32'(rn.rename_stall), 32'd0);
        checkOutput("t6_reset_alloc", 32'(rn.alloc_valid), 32'd0);
        checkOutput("t6_reset_tag", 32'(rn.alloc_tag[0]), 32'd0);
        checkOutput("t6_reset_rat", 32'(rn.rat_write_packet[1]), 32'd0);
        tick();
        reset = 1'b0;
        dispatch2(5'd9, 5'd10);
        checkOutput("t6_count", 32'(rn.free_count), 32'd32);
        checkOutput("t6_run", 32'(rn.rename_stall), 32'd0);
        checkOutput("t6_tag0", 32'(rn.alloc_tag[0]), 32'd32);
        checkOutput("t6_tag1", 32'(rn.alloc_tag[1]), 32'd33);
        tick();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
